board_vga_render: RTL and testbench
===================================

# board_vga_render

Display-side consumer of the game board bus: snapshots the 144-bit board (8 columns × 18 rows, cell index = x + 8·y) once per frame and scans it out as a 640×480 @ 60 Hz VGA image. Generates the `draw_finish` pulse the game controller uses as its 60 Hz tick and as its "board may now change" marker. Sits between the game controller and the board-level VGA pins.

## Interface
- `PIX_DIV`, 4: clk cycles per pixel; 100 MHz clk gives a 25 MHz pixel rate.
- `CELL_PX`, 20: cell edge in pixels; the board is 160×360 px.
- `X0`, 240: left pixel column of the board.
- `Y0`, 60: top pixel line of the board.
- `FG_COLOR`, 8'hFC: RGB332 colour for an occupied cell.
- `BG_COLOR`, 8'h00: colour for an empty cell.
- `BORDER_COLOR`, 8'h49: colour for visible pixels outside the board.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_updated`  in  144  board state, bit x+8·y = cell (x,y) occupied.
- `draw_finish`  out  1  one-clk pulse, once per frame, at the start of vertical blanking.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `rgb`  out  8  RGB332 pixel value; 0 during blanking.

## Operation
- Pixel enable `pix_en`:
  - Divider counts 0..PIX_DIV-1.
  - `pix_en` is high for one clk when the divider reaches PIX_DIV-1.
  - All h/v counters advance only on `pix_en`.
- Horizontal counter `h` counts 0..799:
  - 0–639 visible.
  - 640–655 front porch.
  - 656–751 sync (`hsync`=0).
  - 752–799 back porch.
- Vertical counter `v` counts 0..524:
  - Increments when `h` wraps 799→0.
  - 0–479 visible.
  - 480–489 front porch.
  - 490–491 sync (`vsync`=0).
  - 492–524 back porch.
  - Wraps 524→0.
- Frame snapshot:
  - On the `pix_en` edge where (h,v) becomes (0,480), `snap` <= `data_updated` and `draw_finish` is 1 for exactly that clk.
  - `snap` is the only source of rendered cell data. `data_updated` is never read at any other time.
- Cell addressing uses no divider:
  - Sub-pixel counter `cx_sub` counts 0..CELL_PX-1. Column index `cx` counts 0..7.
  - Both reset at h=X0 and advance on `pix_en`.
  - The same scheme applies vertically: `cy_sub`/`cy` reset at v=Y0 and advance per line.
- Region decode:
  - in_board = X0 ≤ h < X0+160 and Y0 ≤ v < Y0+360.
  - Cell bit = `snap[cx + 8·cy]`. The index is 8 bits wide with a maximum of 143.
- Colour:
  - Blanking (h≥640 or v≥480) gives 0.
  - in_board gives FG_COLOR or BG_COLOR according to the cell bit.
  - Otherwise gives BORDER_COLOR.
- Reset (asynchronous, any time) forces:
  - Divider, h, v and cell counters to 0.
  - `snap` to 0.
  - `draw_finish` to 0, `hsync` and `vsync` to 1, `rgb` to 0.
  - After release, scanning restarts at (0,0). The first `draw_finish` arrives 480 lines later.

## Timing
- `hsync`, `vsync` and `rgb` are registered and aligned to the same pixel.
  - They appear one clk after the `pix_en` edge that sets the corresponding (h,v).
  - Each value is held for PIX_DIV clks.
- `draw_finish` period is 800·525·PIX_DIV clks, i.e. 1 680 000 at default settings.
- Update latency: a `data_updated` change is visible on screen only if it is stable at a `draw_finish` edge.
  - It first appears in the next frame, starting at v=Y0.
  - Changes between snapshots are invisible.
- Simultaneous events:
  - At the h 799→0 wrap with v 479→480, the snapshot and pulse occur on the same edge.
  - Row counters do not advance during blanking.
- `rgb` must be exactly 0 whenever `hsync` or `vsync` is low.

## Structure
- Package `vga_pkg` holds:
  - Constants H_VIS/H_FP/H_SYNC/H_BP and V_VIS/V_FP/V_SYNC/V_BP.
  - BOARD_W=8, BOARD_H=18, BOARD_BITS=144.
  - Function `cell_index(x,y)` returning x+8·y, shared with the game controller.
- Sub-module `vga_timing` contains the pixel divider, h/v counters, sync generation and `visible`/`frame_start` strobes.
- The top level adds the snapshot register, cell counters, colour mux and output registers.

## Test plan
- Reset release, then run one frame:
  - `draw_finish` pulses are exactly 1 680 000 clks apart.
  - Each pulse is 1 clk wide.
  - `hsync` low for 384 clks per line; `vsync` low for 2 lines.
- `data_updated` with only bit 0 set, held across a `draw_finish`:
  - Next frame, pixels h=240–259, v=60–79 are 8'hFC.
  - Pixel (260,60) is 8'h00.
  - Pixel (239,60) is 8'h49.
- Bit 143 set (cell 7,17): pixels h=380–399, v=400–419 are FG; pixel (400,419) is BORDER.
- Toggle `data_updated` between two `draw_finish` pulses: the rendered frame reflects only the value present at the pulse edge.
- Assert `rst_n` low mid-line at v=300:
  - Outputs immediately go to `hsync`=1, `vsync`=1, `rgb`=0, `draw_finish`=0.
  - After release, (h,v) restarts at (0,0).
- Sample `rgb` throughout blanking intervals: always 0, including at the board/blanking edges h=639/640 and v=479/480.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_pkg - 640x480@60 timing and game-board geometry shared definitions. Rev 1.0
//------------------------------------------------------------------------------
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int BOARD_W    = 8;
  localparam int BOARD_H    = 18;
  localparam int BOARD_BITS = 144;

  function automatic logic [7:0] cell_index(input logic [2:0] x, input logic [4:0] y);
    return {5'd0, x} + {y, 3'd0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_timing - pixel divider, h/v scan counters, sync and frame strobes. Rev 1.0
//------------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = H_VIS,
  parameter int H_FRONT  = H_FP,
  parameter int H_PULSE  = H_SYNC,
  parameter int H_BACK   = H_BP,
  parameter int V_ACTIVE = V_VIS,
  parameter int V_FRONT  = V_FP,
  parameter int V_PULSE  = V_SYNC,
  parameter int V_BACK   = V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_en_o,
  output logic          line_end_o,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          visible_o,
  output logic          frame_start_o
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          pix_en;
  logic          line_end;

  always_comb begin
    pix_en   = (div_q == DW'(PIX_DIV - 1));
    line_end = pix_en && (h_q == HW'(H_TOTAL - 1));
    div_d    = pix_en ? '0 : div_q + 1'b1;
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en) begin
      h_d = line_end ? '0 : h_q + 1'b1;
    end
    if (line_end) begin
      v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign pix_en_o   = pix_en;
  assign line_end_o = line_end;
  assign h_o        = h_q;
  assign v_o        = v_q;
  assign hsync_o    = !((h_q >= HW'(H_ACTIVE + H_FRONT)) &&
                        (h_q <  HW'(H_ACTIVE + H_FRONT + H_PULSE)));
  assign vsync_o    = !((v_q >= VW'(V_ACTIVE + V_FRONT)) &&
                        (v_q <  VW'(V_ACTIVE + V_FRONT + V_PULSE)));
  assign visible_o  = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
  // True on the edge that moves the scan to (0, V_ACTIVE).
  assign frame_start_o = line_end && (v_q == VW'(V_ACTIVE - 1));

endmodule
`default_nettype wire

// File: rtl/board_vga_render.sv
`default_nettype none
//------------------------------------------------------------------------------
// board_vga_render - per-frame board snapshot scanned out as a VGA image. Rev 1.0
//------------------------------------------------------------------------------
module board_vga_render
  import vga_pkg::*;
#(
  parameter int          PIX_DIV      = 4,
  parameter int          CELL_PX      = 20,
  parameter int          X0           = 240,
  parameter int          Y0           = 60,
  parameter logic [7:0]  FG_COLOR     = 8'hFC,
  parameter logic [7:0]  BG_COLOR     = 8'h00,
  parameter logic [7:0]  BORDER_COLOR = 8'h49,
  parameter int          H_ACTIVE     = H_VIS,
  parameter int          H_FRONT      = H_FP,
  parameter int          H_PULSE      = H_SYNC,
  parameter int          H_BACK       = H_BP,
  parameter int          V_ACTIVE     = V_VIS,
  parameter int          V_FRONT      = V_FP,
  parameter int          V_PULSE      = V_SYNC,
  parameter int          V_BACK       = V_BP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BOARD_BITS-1:0] data_updated,
  output logic                  draw_finish,
  output logic                  hsync,
  output logic                  vsync,
  output logic [7:0]            rgb
);

  localparam int HW = $clog2(H_ACTIVE + H_FRONT + H_PULSE + H_BACK);
  localparam int VW = $clog2(V_ACTIVE + V_FRONT + V_PULSE + V_BACK);
  localparam int SW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  logic          pix_en, line_end, visible, frame_start, hsync_raw, vsync_raw;
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  vga_timing #(
    .PIX_DIV (PIX_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_PULSE(H_PULSE), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_PULSE(V_PULSE), .V_BACK(V_BACK)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_en_o     (pix_en),
    .line_end_o   (line_end),
    .h_o          (h),
    .v_o          (v),
    .hsync_o      (hsync_raw),
    .vsync_o      (vsync_raw),
    .visible_o    (visible),
    .frame_start_o(frame_start)
  );

  logic [BOARD_BITS-1:0] snap_q;
  logic [SW-1:0]         cx_sub_q, cx_sub_d, cy_sub_q, cy_sub_d;
  logic [2:0]            cx_q, cx_d;
  logic [4:0]            cy_q, cy_d;
  logic                  hsync_q, vsync_q, draw_finish_q;
  logic [7:0]            rgb_q, rgb_d;
  logic                  in_bx, in_by, cell_bit;
  logic [7:0]            cell_idx;

  assign in_bx    = (h >= HW'(X0)) && (h < HW'(X0 + CELL_PX * BOARD_W));
  assign in_by    = (v >= VW'(Y0)) && (v < VW'(Y0 + CELL_PX * BOARD_H));
  assign cell_idx = cell_index(cx_q, cy_q);
  assign cell_bit = snap_q[cell_idx];

  // Cell counters track the scan position directly; they are cleared one
  // pixel (or line) before the board edge so they read 0 at X0 / Y0.
  always_comb begin
    cx_sub_d = cx_sub_q;
    cx_d     = cx_q;
    cy_sub_d = cy_sub_q;
    cy_d     = cy_q;
    if (pix_en) begin
      if (h == HW'(X0 - 1)) begin
        cx_sub_d = '0;
        cx_d     = '0;
      end else if (in_bx) begin
        if (cx_sub_q == SW'(CELL_PX - 1)) begin
          cx_sub_d = '0;
          cx_d     = cx_q + 1'b1;
        end else begin
          cx_sub_d = cx_sub_q + 1'b1;
        end
      end
    end
    if (line_end) begin
      if (v == VW'(Y0 - 1)) begin
        cy_sub_d = '0;
        cy_d     = '0;
      end else if (in_by) begin
        if (cy_sub_q == SW'(CELL_PX - 1)) begin
          cy_sub_d = '0;
          cy_d     = cy_q + 1'b1;
        end else begin
          cy_sub_d = cy_sub_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rgb_d = BORDER_COLOR;
    if (!visible) begin
      rgb_d = '0;
    end else if (in_bx && in_by) begin
      rgb_d = cell_bit ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q        <= '0;
      cx_sub_q      <= '0;
      cx_q          <= '0;
      cy_sub_q      <= '0;
      cy_q          <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= '0;
      draw_finish_q <= 1'b0;
    end else begin
      cx_sub_q      <= cx_sub_d;
      cx_q          <= cx_d;
      cy_sub_q      <= cy_sub_d;
      cy_q          <= cy_d;
      hsync_q       <= hsync_raw;
      vsync_q       <= vsync_raw;
      rgb_q         <= rgb_d;
      draw_finish_q <= frame_start;
      if (frame_start) begin
        snap_q <= data_updated;
      end
    end
  end

  assign draw_finish = draw_finish_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_board_vga_render.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_board_vga_render - directed self-checking bench on a reduced scan geometry. Rev 1.0
//------------------------------------------------------------------------------
module tb_board_vga_render;

  localparam int D   = 2;
  localparam int HA  = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA  = 48, VF = 2, VS = 2, VB = 4;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int X0  = 10;
  localparam int Y0  = 4;
  localparam int CP  = 2;
  localparam logic [7:0] FG = 8'hFC;
  localparam logic [7:0] BG = 8'h00;
  localparam logic [7:0] BD = 8'h49;
  localparam int FRAME_CLK = HT * VT * D;
  localparam int FIRST_DF  = VA * HT * D;
  localparam int PB_T      = (Y0 * HT + X0) * D + 1;
  localparam int RST_T     = ((VT - VA + 30) * HT + 20) * D + 1;

  localparam logic [143:0] PAT_A = 144'h1;
  localparam logic [143:0] PAT_B = {1'b1, 143'h0};
  localparam logic [143:0] PAT_C = {144{1'b1}};

  logic         clk;
  logic         rst_n;
  logic [143:0] data_updated;
  logic         draw_finish;
  logic         hsync;
  logic         vsync;
  logic [7:0]   rgb;

  board_vga_render #(
    .PIX_DIV(D), .CELL_PX(CP), .X0(X0), .Y0(Y0),
    .FG_COLOR(8'hFC), .BG_COLOR(8'h00), .BORDER_COLOR(8'h49),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VS), .V_BACK(VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_updated(data_updated),
    .draw_finish (draw_finish),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] obs_rgb [1:3][VT][HT];
  logic       obs_hs  [1:3][VT][HT];
  logic       obs_vs  [1:3][VT][HT];

  typedef struct {
    int         f;
    int         h;
    int         v;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_rgb(input logic [143:0] s, input int h, input int v);
    int idx;
    if (h >= HA || v >= VA) return 8'h00;
    if (h >= X0 && h < X0 + 8 * CP && v >= Y0 && v < Y0 + 18 * CP) begin
      idx = (h - X0) / CP + 8 * ((v - Y0) / CP);
      return s[idx[7:0]] ? FG : BG;
    end
    return BD;
  endfunction

  // Entered at the negedge just after a draw_finish edge; returns at the
  // negedge just after the next one.
  task automatic capture_frame(input int f, input string tag);
    int hs_low = 0, vs_low = 0, df_cnt = 0, df_t = -1, hold_err = 0;
    int p, h, v;
    for (int t = 1; t <= FRAME_CLK; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (draw_finish) begin
        df_cnt++;
        df_t = t;
      end
      p = (t - 1) / D;
      h = p % HT;
      v = (VA + p / HT) % VT;
      if ((t - 1) % D == 0) begin
        obs_rgb[f][v][h] = rgb;
        obs_hs[f][v][h]  = hsync;
        obs_vs[f][v][h]  = vsync;
      end else if (rgb !== obs_rgb[f][v][h] || hsync !== obs_hs[f][v][h] ||
                   vsync !== obs_vs[f][v][h]) begin
        hold_err++;
      end
    end
    check({tag, " hsync low clks/frame"}, hs_low, VT * HS * D);
    check({tag, " vsync low clks/frame"}, vs_low, VS * HT * D);
    check({tag, " draw_finish pulses"}, df_cnt, 1);
    check({tag, " draw_finish period"}, df_t, FRAME_CLK);
    check({tag, " output hold errors"}, hold_err, 0);
  endtask

  task automatic check_frame(input int f, input logic [143:0] s, input string tag);
    int bad_rgb = 0, bad_sync = 0, bad_blank = 0;
    logic ehs, evs;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        ehs = !(h >= HA + HF && h < HA + HF + HS);
        evs = !(v >= VA + VF && v < VA + VF + VS);
        if (obs_rgb[f][v][h] !== model_rgb(s, h, v)) bad_rgb++;
        if (obs_hs[f][v][h] !== ehs || obs_vs[f][v][h] !== evs) bad_sync++;
        if ((!obs_hs[f][v][h] || !obs_vs[f][v][h]) && obs_rgb[f][v][h] !== 8'h00) bad_blank++;
      end
    end
    check({tag, " rgb pixel errors"}, bad_rgb, 0);
    check({tag, " sync pixel errors"}, bad_sync, 0);
    check({tag, " rgb nonzero in sync"}, bad_blank, 0);
  endtask

  task automatic after_release(input string tag);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 2 * FRAME_CLK) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, " rgb at (0,0)"}, rgb, BD);
        check({tag, " hsync at (0,0)"}, hsync, 1);
      end
      if (n == PB_T) check({tag, " rgb at (X0,Y0) before snapshot"}, rgb, BG);
      if (draw_finish) seen = 1;
    end
    check({tag, " first draw_finish clk"}, n, FIRST_DF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{1, 10,  4, 8'hFC}, '{1, 11,  5, 8'hFC}, '{1, 12,  4, 8'h00}, '{1,  9,  4, 8'h49},
      '{1, 10,  3, 8'h49}, '{1, 10,  6, 8'h00}, '{1,  0,  0, 8'h49}, '{1, 39, 47, 8'h49},
      '{1, 40, 47, 8'h00}, '{1, 39, 48, 8'h00},
      '{2, 24, 38, 8'hFC}, '{2, 25, 39, 8'hFC}, '{2, 26, 39, 8'h49}, '{2, 23, 39, 8'h00},
      '{2, 25, 40, 8'h49}, '{2, 24, 37, 8'h00}, '{2, 10,  4, 8'h00},
      '{3, 10,  4, 8'hFC}, '{3, 25, 39, 8'hFC}, '{3,  9, 20, 8'h49}, '{3, 26, 20, 8'h49},
      '{3, 17, 21, 8'hFC}
    };

    rst_n        = 1'b0;
    data_updated = PAT_A;
    repeat (3) @(negedge clk);
    check("reset draw_finish", draw_finish, 0);
    check("reset hsync", hsync, 1);
    check("reset vsync", vsync, 1);
    check("reset rgb", rgb, 0);
    rst_n = 1'b1;
    after_release("por");

    fork
      capture_frame(1, "frame1");
      begin
        repeat (2000) @(negedge clk);
        data_updated = PAT_C;
        repeat (2000) @(negedge clk);
        data_updated = PAT_B;
      end
    join
    fork
      capture_frame(2, "frame2");
      begin
        repeat (100) @(negedge clk);
        data_updated = PAT_C;
      end
    join
    capture_frame(3, "frame3");

    repeat (RST_T) @(posedge clk);
    @(negedge clk);
    check("pre-reset rgb at (20,30)", rgb, FG);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset draw_finish", draw_finish, 0);
    check("async reset hsync", hsync, 1);
    check("async reset vsync", vsync, 1);
    check("async reset rgb", rgb, 0);
    repeat (3) @(negedge clk);
    check("held reset rgb", rgb, 0);
    rst_n = 1'b1;
    after_release("mid");

    check_frame(1, PAT_A, "frame1");
    check_frame(2, PAT_B, "frame2");
    check_frame(3, PAT_C, "frame3");
    for (int i = 0; i < 22; i++) begin
      check($sformatf("vec%0d f%0d rgb(%0d,%0d)", i, vecs[i].f, vecs[i].h, vecs[i].v),
            obs_rgb[vecs[i].f][vecs[i].v][vecs[i].h], vecs[i].exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
